// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package im_loader_pkg;

  localparam int OPC_W   = 7;
  localparam int LIT_W   = 8;
  localparam int INSTR_W = OPC_W + LIT_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CHK   = 3'd4,
    S_FIN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // States in which a stream byte can be taken.
  function automatic logic accepts_byte(state_t s);
    return (s == S_COUNT) || (s == S_HI) || (s == S_LO) || (s == S_CHK);
  endfunction

  // States in which the CPU must stay frozen.
  function automatic logic holds_cpu(state_t s);
    return accepts_byte(s) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/im_loader.sv
// Byte-stream program loader: COUNT, then (HI, LO) pairs written to IM from address 0.
// Optional trailing checksum byte enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              pc_clear,
  output logic              done,
  output logic              error
);
  import im_loader_pkg::*;

  localparam logic [ADDR_W:0] FULL_LOAD = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  state_t            nxt;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W:0]   remaining;
  logic              xfer;
  logic              start_ok;

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state == S_IDLE) || (state == S_ERR));

  // Next-state decision for the load sequencer.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (start) nxt = S_COUNT;
        else       nxt = S_IDLE;
      end
      S_COUNT: begin
        if (xfer) nxt = S_HI;
        else      nxt = S_COUNT;
      end
      S_HI: begin
        if (xfer && in_data[7])       nxt = S_ERR;
        else if (xfer)                nxt = S_LO;
        else                          nxt = S_HI;
      end
      S_LO: begin
        if (xfer && (remaining == LAST_ONE)) begin
`ifdef IM_LOADER_CHECKSUM_EN
          nxt = S_CHK;
`else
          nxt = S_FIN;
`endif
        end else if (xfer) begin
          nxt = S_HI;
        end else begin
          nxt = S_LO;
        end
      end
      S_CHK: begin
`ifdef IM_LOADER_CHECKSUM_EN
        if (xfer && (in_data == sum)) nxt = S_FIN;
        else if (xfer)                nxt = S_ERR;
        else                          nxt = S_CHK;
`else
        nxt = S_IDLE;
`endif
      end
      S_FIN: nxt = S_IDLE;
      S_ERR: begin
        if (start) nxt = S_COUNT;
        else       nxt = S_ERR;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      cpu_hold  <= 1'b0;
      error     <= 1'b0;
      done      <= 1'b0;
      pc_clear  <= 1'b0;
      im_we     <= 1'b0;
      im_addr   <= {ADDR_W{1'b0}};
      im_wdata  <= {INSTR_W{1'b0}};
      opcode    <= {OPC_W{1'b0}};
      remaining <= {(ADDR_W+1){1'b0}};
`ifdef IM_LOADER_CHECKSUM_EN
      sum       <= 8'd0;
`endif
    end else begin
      state    <= nxt;
      in_ready <= accepts_byte(nxt);
      cpu_hold <= holds_cpu(nxt);
      error    <= (nxt == S_ERR);
      done     <= (nxt == S_FIN);
      pc_clear <= (nxt == S_FIN);
      im_we    <= (state == S_LO) && xfer;

      // The address advances on the edge that ends the strobe cycle.
      if (im_we) im_addr <= im_addr + ADDR_W'(1);
      if (start_ok) im_addr <= {ADDR_W{1'b0}};

      if ((state == S_COUNT) && xfer) begin
        remaining <= (in_data == 8'd0) ? FULL_LOAD : (ADDR_W+1)'(in_data);
`ifdef IM_LOADER_CHECKSUM_EN
        sum       <= in_data;
`endif
      end

      if ((state == S_HI) && xfer) begin
        opcode <= in_data[OPC_W-1:0];
`ifdef IM_LOADER_CHECKSUM_EN
        sum    <= sum + in_data;
`endif
      end

      if ((state == S_LO) && xfer) begin
        im_wdata  <= INSTR_W'({opcode, in_data});
        remaining <= remaining - LAST_ONE;
`ifdef IM_LOADER_CHECKSUM_EN
        sum       <= sum + in_data;
`endif
      end
    end
  end

endmodule
